// File: rtl/unstripe_pkg.sv
// unstripe_pkg: shared FSM state, lane indices and sizing helper for unstripe_sched
package unstripe_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;
  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/lane_fifo.sv
// lane_fifo: per-lane word buffer with flush, pop-frees-slot push acceptance and drop flag
module lane_fifo
  import unstripe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              drop
);
  localparam int AW = clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic wr, rd;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign rd    = pop && !empty && !flush;
  assign wr    = push && (!full || rd) && !flush;
  assign drop  = push && full && !rd && !flush;
  assign dout  = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd ? rd_q + 1'b1 : rd_q;
      wr_q  <= wr ? wr_q + 1'b1 : wr_q;
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/unstripe_sched.sv
// unstripe_sched: round-robin two-lane merge with starvation realign; UNSTRIPE_SCHED_STATS_EN adds stall/realign counters
module unstripe_sched
  import unstripe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int STALL_MAX  = 8
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] lane0,
  input  logic              valid0,
  input  logic [DATA_W-1:0] lane1,
  input  logic              valid1,
  output logic [DATA_W-1:0] dataOut,
  output logic              validOut,
  output logic              lane_id,
  output logic              realign,
  output logic              overflow0,
`ifdef UNSTRIPE_SCHED_STATS_EN
  output logic              overflow1,
  output logic [15:0]       stall_count,
  output logic [7:0]        realign_count
`else
  output logic              overflow1
`endif
);
  localparam int SW = clog2(STALL_MAX + 1);
  state_t state_q, state_d;
  logic nxt_q, nxt_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [DATA_W-1:0] data_q, dout0, dout1;
  logic valid_q, lane_q, realign_q, ovf0_q, ovf1_q;
  logic empty0, empty1, full0, full1, drop0, drop1;
  logic run, pop0, pop1, starve, flush, go;
  assign run    = state_q == RUN;
  assign pop0   = run && nxt_q == LANE0 && !empty0;
  assign pop1   = run && nxt_q == LANE1 && !empty1;
  assign starve = run && (nxt_q == LANE1 ? empty1 : empty0);
  assign flush  = starve && stall_q == SW'(STALL_MAX - 1);
  assign go     = !run && (!empty0 || (valid0 && !full0)) && (!empty1 || (valid1 && !full1));
  always_comb begin
    state_d = flush ? IDLE : go ? RUN : state_q;
    nxt_d   = flush ? LANE0 : (pop0 || pop1) ? !nxt_q : nxt_q;
    stall_d = (flush || !starve) ? '0 : stall_q + 1'b1;
  end
  lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk_2f), .rst(reset), .push(valid0), .pop(pop0), .flush(flush),
    .din(lane0), .dout(dout0), .empty(empty0), .full(full0), .drop(drop0)
  );
  lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk_2f), .rst(reset), .push(valid1), .pop(pop1), .flush(flush),
    .din(lane1), .dout(dout1), .empty(empty1), .full(full1), .drop(drop1)
  );
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q   <= IDLE;
      nxt_q     <= LANE0;
      stall_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      lane_q    <= LANE0;
      realign_q <= 1'b0;
      ovf0_q    <= 1'b0;
      ovf1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      nxt_q     <= nxt_d;
      stall_q   <= stall_d;
      data_q    <= pop1 ? dout1 : pop0 ? dout0 : data_q;
      valid_q   <= pop0 || pop1;
      lane_q    <= (pop0 || pop1) ? pop1 : lane_q;
      realign_q <= flush;
      ovf0_q    <= ovf0_q || drop0;
      ovf1_q    <= ovf1_q || drop1;
    end
  end
  assign dataOut   = data_q;
  assign validOut  = valid_q;
  assign lane_id   = lane_q;
  assign realign   = realign_q;
  assign overflow0 = ovf0_q;
  assign overflow1 = ovf1_q;
`ifdef UNSTRIPE_SCHED_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [7:0] realign_cnt_q;
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      stall_cnt_q   <= '0;
      realign_cnt_q <= '0;
    end else begin
      stall_cnt_q   <= (starve && !(&stall_cnt_q)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
      realign_cnt_q <= (flush && !(&realign_cnt_q)) ? realign_cnt_q + 8'd1 : realign_cnt_q;
    end
  end
  assign stall_count   = stall_cnt_q;
  assign realign_count = realign_cnt_q;
`endif
endmodule

// File: tb/tb_unstripe_sched.sv
// tb_unstripe_sched: directed self-checking bench for unstripe_sched
module tb_unstripe_sched;
  localparam int W = 32;
  logic clk_2f = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] lane0 = '0, lane1 = '0;
  logic valid0 = 1'b0, valid1 = 1'b0;
  logic [W-1:0] dataOut;
  logic validOut, lane_id, realign, overflow0, overflow1;
  int n_chk = 0;
  int n_fail = 0;
`ifdef UNSTRIPE_SCHED_STATS_EN
  logic [15:0] stall_count;
  logic [7:0] realign_count;
`endif
  always #5 clk_2f = ~clk_2f;
  unstripe_sched #(.DATA_W(W), .FIFO_DEPTH(4), .STALL_MAX(8)) dut (
    .clk_2f(clk_2f), .reset(reset),
    .lane0(lane0), .valid0(valid0), .lane1(lane1), .valid1(valid1),
    .dataOut(dataOut), .validOut(validOut), .lane_id(lane_id), .realign(realign),
`ifdef UNSTRIPE_SCHED_STATS_EN
    .overflow0(overflow0), .overflow1(overflow1),
    .stall_count(stall_count), .realign_count(realign_count)
`else
    .overflow0(overflow0), .overflow1(overflow1)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_2f);
    #1;
  endtask
  task automatic drive(input logic v0, input logic [W-1:0] d0, input logic v1, input logic [W-1:0] d1);
    valid0 = v0;
    lane0  = d0;
    valid1 = v1;
    lane1  = d1;
  endtask
  task automatic out(input string tag, input logic [W-1:0] d, input logic l);
    step();
    chk({tag, "_valid"}, 64'(validOut), 64'(1'b1));
    chk({tag, "_data"}, 64'(dataOut), 64'(d));
    chk({tag, "_lane"}, 64'(lane_id), 64'(l));
  endtask
  task automatic expect_realign(input string tag);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk({tag, "_realign"}, 64'(realign), 64'(i == 8));
      chk({tag, "_stallvalid"}, 64'(validOut), 64'(1'b0));
    end
    step();
    chk({tag, "_realign_end"}, 64'(realign), 64'(1'b0));
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, 64'(dataOut), 64'(0));
    chk({tag, "_valid"}, 64'(validOut), 64'(0));
    chk({tag, "_lane"}, 64'(lane_id), 64'(0));
    chk({tag, "_realign"}, 64'(realign), 64'(0));
    chk({tag, "_ovf0"}, 64'(overflow0), 64'(0));
    chk({tag, "_ovf1"}, 64'(overflow1), 64'(0));
`ifdef UNSTRIPE_SCHED_STATS_EN
    chk({tag, "_stallcnt"}, 64'(stall_count), 64'(0));
    chk({tag, "_rlcnt"}, 64'(realign_count), 64'(0));
`endif
  endtask
  initial begin
    step();
    step();
    reset = 1'b0;
    check_reset_outputs("rst");
    drive(1, 32'hA000_0000, 1, 32'hB000_0000);
    step();
    chk("s1_lat", 64'(validOut), 64'(0));
    drive(1, 32'hA000_0001, 1, 32'hB000_0001);
    out("s1_a0", 32'hA000_0000, 0);
    drive(0, '0, 0, '0);
    out("s1_b0", 32'hB000_0000, 1);
    out("s1_a1", 32'hA000_0001, 0);
    out("s1_b1", 32'hB000_0001, 1);
    expect_realign("s1");
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, 1, 32'hB100_0000 + 32'(i));
      step();
      chk("s2_idle", 64'(validOut), 64'(0));
    end
    drive(0, '0, 0, '0);
    repeat (3) step();
    chk("s2_idle_hold", 64'(validOut), 64'(0));
    chk("s2_ovf1", 64'(overflow1), 64'(0));
    drive(1, 32'hA100_0000, 0, '0);
    step();
    chk("s2_lat", 64'(validOut), 64'(0));
    drive(0, '0, 0, '0);
    out("s2_a0", 32'hA100_0000, 0);
    out("s2_b0", 32'hB100_0000, 1);
    expect_realign("s2");
    drive(1, 32'hA500_0000, 1, 32'hB500_0000);
    step();
    drive(0, '0, 0, '0);
    out("s2_realigned_a", 32'hA500_0000, 0);
    out("s2_realigned_b", 32'hB500_0000, 1);
    expect_realign("s2b");
    drive(1, 32'hA200_0000, 1, 32'hB200_0000);
    step();
    drive(1, 32'hA200_0001, 0, '0);
    out("s3_a0", 32'hA200_0000, 0);
    drive(1, 32'hA200_0002, 0, '0);
    out("s3_b0", 32'hB200_0000, 1);
    drive(0, '0, 0, '0);
    out("s3_a1", 32'hA200_0001, 0);
    expect_realign("s3");
    drive(1, 32'hA900_0000, 1, 32'hB900_0000);
    step();
    drive(0, '0, 0, '0);
    out("s3_flushed_a", 32'hA900_0000, 0);
    out("s3_flushed_b", 32'hB900_0000, 1);
    expect_realign("s3b");
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'hC000_0000 + 32'(i), 0, '0);
      step();
      chk("s4_ovf0", 64'(overflow0), 64'(i == 4));
    end
    drive(0, '0, 0, '0);
    repeat (3) step();
    chk("s4_ovf0_held", 64'(overflow0), 64'(1));
    chk("s4_ovf1", 64'(overflow1), 64'(0));
    chk("s4_idle", 64'(validOut), 64'(0));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_outputs("s4_rst");
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hC100_0000 + 32'(i), 0, '0);
      step();
    end
    chk("s5_fill_ovf0", 64'(overflow0), 64'(0));
    drive(0, '0, 1, 32'hD000_0000);
    step();
    drive(1, 32'hC100_0004, 1, 32'hD000_0001);
    out("s5_c0", 32'hC100_0000, 0);
    drive(0, '0, 1, 32'hD000_0002);
    out("s5_d0", 32'hD000_0000, 1);
    drive(0, '0, 1, 32'hD000_0003);
    out("s5_c1", 32'hC100_0001, 0);
    drive(0, '0, 0, '0);
    out("s5_d1", 32'hD000_0001, 1);
    out("s5_c2", 32'hC100_0002, 0);
    out("s5_d2", 32'hD000_0002, 1);
    out("s5_c3", 32'hC100_0003, 0);
    out("s5_d3", 32'hD000_0003, 1);
    out("s5_c4", 32'hC100_0004, 0);
    chk("s5_no_drop", 64'(overflow0), 64'(0));
    expect_realign("s5");
`ifdef UNSTRIPE_SCHED_STATS_EN
    chk("s5_stallcnt", 64'(stall_count), 64'(8));
    chk("s5_rlcnt", 64'(realign_count), 64'(1));
`endif
    drive(1, 32'hE000_0000, 1, 32'hF000_0000);
    step();
    drive(1, 32'hE000_0001, 1, 32'hF000_0001);
    out("s6_e0", 32'hE000_0000, 0);
    drive(0, '0, 0, '0);
    out("s6_f0", 32'hF000_0000, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_outputs("s6_rst");
    step();
    step();
    chk("s6_lost", 64'(validOut), 64'(0));
    drive(1, 32'h6000_0000, 1, 32'h7000_0000);
    step();
    drive(0, '0, 0, '0);
    out("s6_g0", 32'h6000_0000, 0);
    out("s6_h0", 32'h7000_0000, 1);
    expect_realign("s6");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
